nibble_frame_collector: RTL and testbench

Upstream stage of the 16-input minimum finder. Accepts a serial stream of 4-bit samples over a valid/ready handshake, packs them into a 16-word frame, and presents the frame as a stable 64-bit parallel bus with an output valid/ready handshake. Short frames, closed early by a last flag, are padded with 4'hF. The minimum finder treats 15 as its initial value, so padded slots never become min1, min2 or index_min1.

---
 rtl/nibble_frame_collector_if.sv | 32 +++
 rtl/nibble_frame_collector.sv | 205 ++++++++++++++++++++
 tb/tb_nibble_frame_collector.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nibble_frame_collector_if.sv
`default_nettype none
// ============================================================================
// Module   : nibble_frame_collector_if
// Brief    : Sample-in / frame-out handshake bundle for the nibble frame
//            collector. "master" is the upstream/downstream environment,
//            "slave" is the collector itself.
// Revision : 1.0 - initial release
// ============================================================================
interface nibble_frame_collector_if #(
    parameter int WORDS = 16,
    parameter int W     = 4
);
    logic                   in_valid;
    logic [W-1:0]           in_data;
    logic                   in_last;
    logic                   in_ready;
    logic                   out_valid;
    logic                   out_ready;
    logic [WORDS*W-1:0]     out_frame;
    logic [4:0]             out_count;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_frame, out_count
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_frame, out_count
    );
endinterface
`default_nettype wire

// File: rtl/nibble_frame_collector.sv
`default_nettype none
// ============================================================================
// Module   : nibble_frame_collector
// Brief    : Packs a serial stream of 4-bit samples into a 16-word frame,
//            padding short frames (closed by in_last) with 4'hF, and presents
//            the frame on a stable 64-bit bus with a valid/ready handshake.
//            Optional macro NIBBLE_FRAME_COLLECTOR_PINGPONG_EN selects a
//            two-bank build that fills one bank while the other is held.
// Revision : 1.0 - initial release
// ============================================================================
module nibble_frame_collector #(
    parameter int WORDS = 16,
    parameter int W     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    nibble_frame_collector_if.slave bus
);

    // Index of the final slot; a frame always closes on it.
    localparam logic [3:0]   c_LAST_IDX = 4'(WORDS - 1);
    // Pad value: the downstream minimum finder starts from 15, so padding
    // can never win a minimum.
    localparam logic [W-1:0] c_PAD      = {W{1'b1}};

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // Slots currently shown on out_frame.
    logic [W-1:0] w_pres_slot [WORDS];

`ifdef NIBBLE_FRAME_COLLECTOR_PINGPONG_EN

    state_t       bank_st_q   [2];
    state_t       bank_st_d   [2];
    logic [W-1:0] bank_slot_q [2][WORDS];
    logic [W-1:0] bank_slot_d [2][WORDS];
    logic [4:0]   bank_cnt_q  [2];
    logic [4:0]   bank_cnt_d  [2];
    logic         pres_q, pres_d;
    logic [3:0]   wr_idx_q, wr_idx_d;

    logic         w_fill_sel;
    logic         w_out_valid;
    logic         w_in_ready;
    logic         w_accept;
    logic         w_release;

    // Bank bookkeeping: the presented bank fills until it closes, after
    // which the other bank fills; release hands presentation to the other
    // bank so frame order follows closing order.
    always_comb begin
        w_fill_sel  = (bank_st_q[pres_q] == ST_HOLD) ? ~pres_q : pres_q;
        w_out_valid = (bank_st_q[pres_q] == ST_HOLD);
        w_in_ready  = !((bank_st_q[0] == ST_HOLD) && (bank_st_q[1] == ST_HOLD));
        w_accept    = bus.in_valid && w_in_ready;
        w_release   = w_out_valid && bus.out_ready;

        bank_st_d   = bank_st_q;
        bank_slot_d = bank_slot_q;
        bank_cnt_d  = bank_cnt_q;
        pres_d      = pres_q;
        wr_idx_d    = wr_idx_q;

        // Accept and release never touch the same bank: a release implies
        // the presented bank is held, so filling targets the other one.
        if (w_accept) begin
            bank_slot_d[w_fill_sel][wr_idx_q] = bus.in_data;
            wr_idx_d = wr_idx_q + 4'd1;
            if (bus.in_last || (wr_idx_q == c_LAST_IDX)) begin
                bank_st_d[w_fill_sel]  = ST_HOLD;
                bank_cnt_d[w_fill_sel] = {1'b0, wr_idx_q} + 5'd1;
                wr_idx_d               = 4'd0;
            end
        end

        if (w_release) begin
            bank_st_d[pres_q] = ST_FILL;
            for (int i = 0; i < WORDS; i++) begin
                bank_slot_d[pres_q][i] = c_PAD;
            end
            pres_d = ~pres_q;
        end
    end

    // Bank state, slots, counts and write pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                bank_st_q[b]  <= ST_FILL;
                bank_cnt_q[b] <= 5'd0;
                for (int i = 0; i < WORDS; i++) begin
                    bank_slot_q[b][i] <= c_PAD;
                end
            end
            pres_q   <= 1'b0;
            wr_idx_q <= 4'd0;
        end else begin
            bank_st_q   <= bank_st_d;
            bank_slot_q <= bank_slot_d;
            bank_cnt_q  <= bank_cnt_d;
            pres_q      <= pres_d;
            wr_idx_q    <= wr_idx_d;
        end
    end

    // Select the presented bank onto the output slots.
    always_comb begin
        for (int i = 0; i < WORDS; i++) begin
            w_pres_slot[i] = bank_slot_q[pres_q][i];
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_count = bank_cnt_q[pres_q];

`else

    state_t       state_q, state_d;
    logic [3:0]   wr_idx_q, wr_idx_d;
    logic [W-1:0] slot_q [WORDS];
    logic [W-1:0] slot_d [WORDS];
    logic [4:0]   count_q, count_d;

    logic         w_accept;
    logic         w_release;

    // FILL writes samples into consecutive slots until in_last or the final
    // slot; HOLD freezes the frame until downstream takes it.
    always_comb begin
        state_d   = state_q;
        wr_idx_d  = wr_idx_q;
        slot_d    = slot_q;
        count_d   = count_q;
        w_accept  = 1'b0;
        w_release = 1'b0;

        case (state_q)
            ST_FILL: begin
                w_accept = bus.in_valid;
                if (w_accept) begin
                    slot_d[wr_idx_q] = bus.in_data;
                    wr_idx_d         = wr_idx_q + 4'd1;
                    if (bus.in_last || (wr_idx_q == c_LAST_IDX)) begin
                        state_d = ST_HOLD;
                        count_d = {1'b0, wr_idx_q} + 5'd1;
                    end
                end
            end
            ST_HOLD: begin
                w_release = bus.out_ready;
                if (w_release) begin
                    state_d  = ST_FILL;
                    wr_idx_d = 4'd0;
                    for (int i = 0; i < WORDS; i++) begin
                        slot_d[i] = c_PAD;
                    end
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    // State, slot, count and write pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_FILL;
            wr_idx_q <= 4'd0;
            count_q  <= 5'd0;
            for (int i = 0; i < WORDS; i++) begin
                slot_q[i] <= c_PAD;
            end
        end else begin
            state_q  <= state_d;
            wr_idx_q <= wr_idx_d;
            count_q  <= count_d;
            slot_q   <= slot_d;
        end
    end

    // The single bank is always the presented one.
    always_comb begin
        for (int i = 0; i < WORDS; i++) begin
            w_pres_slot[i] = slot_q[i];
        end
    end

    assign bus.in_ready  = (state_q == ST_FILL);
    assign bus.out_valid = (state_q == ST_HOLD);
    assign bus.out_count = count_q;

`endif

    // Word i occupies bits [4i+3:4i]; word 0 is the first sample received.
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_pack
        assign bus.out_frame[gi*W +: W] = w_pres_slot[gi];
    end

endmodule
`default_nettype wire

// File: tb/tb_nibble_frame_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_frame_collector
// Brief    : Self-checking bench for nibble_frame_collector. A queue-based
//            model turns accepted samples into expected frames; handshake
//            expectations follow from the number of closed, unreleased
//            frames (1 bank or 2 banks with NIBBLE_FRAME_COLLECTOR_PINGPONG_EN).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_nibble_frame_collector;

    localparam int WORDS = 16;
    localparam int W     = 4;
`ifdef NIBBLE_FRAME_COLLECTOR_PINGPONG_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    nibble_frame_collector_if #(.WORDS(WORDS), .W(W)) bus ();

    nibble_frame_collector #(.WORDS(WORDS), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: samples of the frame being built, and closed frames
    // waiting to be taken downstream, oldest first.
    logic [3:0]  cur_q[$];
    logic [63:0] exp_frames[$];
    logic [4:0]  exp_counts[$];

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        obs_rdy;
        logic        obs_vld;
        logic        exp_rdy;
        logic        exp_vld;
        logic        rel;
        logic [63:0] got_f;
        logic [63:0] exp_f;
        logic [4:0]  got_c;
        logic [4:0]  exp_c;
    } step_t;

    function automatic void close_frame();
        logic [63:0] f;
        f = '1;
        for (int i = 0; i < cur_q.size(); i++) f[i*4 +: 4] = cur_q[i];
        exp_frames.push_back(f);
        exp_counts.push_back(5'(cur_q.size()));
        cur_q.delete();
    endfunction

    // One clock cycle: drive at negedge, sample, let the edge happen, update
    // the model, return at the next negedge.
    task automatic step(input logic v, input logic [3:0] d, input logic l,
                        input logic r, output step_t s);
        logic acc, rl;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_last   = l;
        bus.out_ready = r;
        #1;
        s         = '0;
        s.obs_rdy = bus.in_ready;
        s.obs_vld = bus.out_valid;
        s.exp_vld = (exp_frames.size() > 0);
        s.exp_rdy = (exp_frames.size() < CAP);
        acc       = v && s.exp_rdy;
        rl        = r && s.exp_vld;
        s.rel     = rl;
        if (rl) begin
            s.got_f = bus.out_frame;
            s.got_c = bus.out_count;
            s.exp_f = exp_frames[0];
            s.exp_c = exp_counts[0];
        end
        @(posedge clk);
        if (rl) begin
            void'(exp_frames.pop_front());
            void'(exp_counts.pop_front());
        end
        if (acc) begin
            cur_q.push_back(d);
            if (l || cur_q.size() == WORDS) close_frame();
        end
        @(negedge clk);
    endtask

    task automatic apply_reset(input logic v);
        rst           = 1'b1;
        bus.in_valid  = v;
        bus.in_data   = 4'($urandom);
        bus.in_last   = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        cur_q.delete();
        exp_frames.delete();
        exp_counts.delete();
    endtask

    task automatic test_reset();
        apply_reset(1'b0);
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid obs=%b exp=0", bus.out_valid); end
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready obs=%b exp=1", bus.in_ready); end
        checks++;
        if (bus.out_count !== 5'd0) begin errors++; $display("FAIL reset_out_count obs=%0d exp=0", bus.out_count); end
        checks++;
        if (bus.out_frame !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL reset_out_frame obs=%h exp=all F", bus.out_frame); end
    endtask

    task automatic test_full_frame();
        step_t s;
        logic [3:0] vals [16];
        vals = '{4'd2, 4'd3, 4'd1, 4'd2, 4'd5, 4'd6, 4'd9, 4'd9,
                 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9};
        for (int i = 0; i < 16; i++) begin
            step(1'b1, vals[i], 1'b0, 1'b0, s);
            checks++;
            if (s.obs_rdy !== s.exp_rdy || s.obs_vld !== s.exp_vld) begin
                errors++; $display("FAIL full_hs rdy,vld obs=%b,%b exp=%b,%b", s.obs_rdy, s.obs_vld, s.exp_rdy, s.exp_vld);
            end
        end
        checks++;
        if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL full_latency out_valid obs=%b exp=1", bus.out_valid); end
        checks++;
        if (bus.out_frame !== 64'h9999_9999_9965_2132) begin errors++; $display("FAIL full_frame obs=%h exp=9999999999652132", bus.out_frame); end
        checks++;
        if (bus.out_count !== 5'd16) begin errors++; $display("FAIL full_count obs=%0d exp=16", bus.out_count); end
        step(1'b0, 4'd0, 1'b0, 1'b1, s);
        checks++;
        if (!s.rel || s.got_f !== s.exp_f || s.got_c !== s.exp_c) begin
            errors++; $display("FAIL full_release rel=%b obs=%h/%0d exp=%h/%0d", s.rel, s.got_f, s.got_c, s.exp_f, s.exp_c);
        end
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL full_after_release vld,rdy obs=%b,%b exp=0,1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_short_frame();
        step_t s;
        logic [3:0] vals [4];
        vals = '{4'd5, 4'd2, 4'd10, 4'd0};
        for (int i = 0; i < 4; i++) begin
            step(1'b1, vals[i], (i == 3), 1'b0, s);
            checks++;
            if (s.obs_rdy !== s.exp_rdy || s.obs_vld !== s.exp_vld) begin
                errors++; $display("FAIL short_hs rdy,vld obs=%b,%b exp=%b,%b", s.obs_rdy, s.obs_vld, s.exp_rdy, s.exp_vld);
            end
        end
        checks++;
        if (bus.out_frame !== 64'hFFFF_FFFF_FFFF_0A25 || bus.out_count !== 5'd4) begin
            errors++; $display("FAIL short_frame obs=%h/%0d exp=FFFFFFFFFFFF0A25/4", bus.out_frame, bus.out_count);
        end
        step(1'b0, 4'd0, 1'b0, 1'b1, s);
        checks++;
        if (!s.rel || s.got_f !== s.exp_f || s.got_c !== s.exp_c) begin
            errors++; $display("FAIL short_release rel=%b obs=%h/%0d exp=%h/%0d", s.rel, s.got_f, s.got_c, s.exp_f, s.exp_c);
        end
    endtask

    task automatic test_single_sample();
        step_t s;
        step(1'b1, 4'd7, 1'b1, 1'b0, s);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_frame !== 64'hFFFF_FFFF_FFFF_FFF7 || bus.out_count !== 5'd1) begin
            errors++; $display("FAIL single_frame vld=%b obs=%h/%0d exp=FFFFFFFFFFFFFFF7/1", bus.out_valid, bus.out_frame, bus.out_count);
        end
        step(1'b0, 4'd0, 1'b0, 1'b1, s);
        checks++;
        if (!s.rel || s.got_f !== s.exp_f || s.got_c !== s.exp_c) begin
            errors++; $display("FAIL single_release rel=%b obs=%h/%0d exp=%h/%0d", s.rel, s.got_f, s.got_c, s.exp_f, s.exp_c);
        end
    endtask

    task automatic test_hold_stall();
        step_t s;
        logic [63:0] held;
        for (int i = 0; i < 3; i++) step(1'b1, 4'($urandom), (i == 2), 1'b0, s);
        held = bus.out_frame;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 4'($urandom), 1'b0, 1'b0, s);
            checks++;
            if (s.obs_rdy !== s.exp_rdy || s.obs_vld !== s.exp_vld) begin
                errors++; $display("FAIL stall_hs rdy,vld obs=%b,%b exp=%b,%b", s.obs_rdy, s.obs_vld, s.exp_rdy, s.exp_vld);
            end
            checks++;
            if (bus.out_frame !== held) begin errors++; $display("FAIL stall_frame_frozen obs=%h exp=%h", bus.out_frame, held); end
        end
        for (int k = 0; k < 12 && (exp_frames.size() > 0 || cur_q.size() > 0); k++) begin
            step(1'b1, 4'($urandom), 1'b1, 1'b1, s);
            checks++;
            if (s.obs_rdy !== s.exp_rdy || s.obs_vld !== s.exp_vld) begin
                errors++; $display("FAIL stall_drain_hs rdy,vld obs=%b,%b exp=%b,%b", s.obs_rdy, s.obs_vld, s.exp_rdy, s.exp_vld);
            end
            if (s.rel) begin
                checks++;
                if (s.got_f !== s.exp_f || s.got_c !== s.exp_c) begin
                    errors++; $display("FAIL stall_release obs=%h/%0d exp=%h/%0d", s.got_f, s.got_c, s.exp_f, s.exp_c);
                end
            end
        end
    endtask

    task automatic test_reset_midfill();
        step_t s;
        for (int i = 0; i < 6; i++) step(1'b1, 4'($urandom_range(14, 0)), 1'b0, 1'b0, s);
        apply_reset(1'b1);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL midrst_hs vld,rdy obs=%b,%b exp=0,1", bus.out_valid, bus.in_ready);
        end
        checks++;
        if (bus.out_frame !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL midrst_frame obs=%h exp=all F", bus.out_frame); end
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 4'($urandom), 1'b0, 1'b0, s);
            checks++;
            if (s.obs_rdy !== s.exp_rdy || s.obs_vld !== s.exp_vld) begin
                errors++; $display("FAIL midrst_hs2 rdy,vld obs=%b,%b exp=%b,%b", s.obs_rdy, s.obs_vld, s.exp_rdy, s.exp_vld);
            end
        end
        step(1'b0, 4'd0, 1'b0, 1'b1, s);
        checks++;
        if (!s.rel || s.got_f !== s.exp_f || s.got_c !== s.exp_c) begin
            errors++; $display("FAIL midrst_release rel=%b obs=%h/%0d exp=%h/%0d", s.rel, s.got_f, s.got_c, s.exp_f, s.exp_c);
        end
    endtask

    task automatic test_back_to_back();
        step_t s;
        int sent;
        sent = 0;
        for (int k = 0; k < 100 && (sent < 32 || exp_frames.size() > 0); k++) begin
            step(sent < 32, 4'($urandom), 1'b0, 1'b1, s);
            if (sent < 32 && s.exp_rdy) sent++;
            checks++;
            if (s.obs_rdy !== s.exp_rdy || s.obs_vld !== s.exp_vld) begin
                errors++; $display("FAIL b2b_hs rdy,vld obs=%b,%b exp=%b,%b", s.obs_rdy, s.obs_vld, s.exp_rdy, s.exp_vld);
            end
`ifdef NIBBLE_FRAME_COLLECTOR_PINGPONG_EN
            checks++;
            if (s.obs_rdy !== 1'b1) begin errors++; $display("FAIL b2b_in_ready_drop obs=%b exp=1", s.obs_rdy); end
`endif
            if (s.rel) begin
                checks++;
                if (s.got_f !== s.exp_f || s.got_c !== s.exp_c) begin
                    errors++; $display("FAIL b2b_release obs=%h/%0d exp=%h/%0d", s.got_f, s.got_c, s.exp_f, s.exp_c);
                end
            end
        end
        checks++;
        if (sent != 32) begin errors++; $display("FAIL b2b_timeout sent=%0d exp=32", sent); end
`ifdef NIBBLE_FRAME_COLLECTOR_PINGPONG_EN
        // Two short frames held together, then released on consecutive cycles.
        for (int i = 0; i < 6; i++) step(1'b1, 4'($urandom), (i % 3 == 2), 1'b0, s);
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
            errors++; $display("FAIL pp_both_full rdy,vld obs=%b,%b exp=0,1", bus.in_ready, bus.out_valid);
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 4'd0, 1'b0, 1'b1, s);
            checks++;
            if (!s.rel || s.obs_vld !== 1'b1 || s.got_f !== s.exp_f || s.got_c !== s.exp_c) begin
                errors++; $display("FAIL pp_swap rel=%b vld=%b obs=%h/%0d exp=%h/%0d", s.rel, s.obs_vld, s.got_f, s.got_c, s.exp_f, s.exp_c);
            end
        end
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL pp_after_swap vld,rdy obs=%b,%b exp=0,1", bus.out_valid, bus.in_ready);
        end
`endif
    endtask

    task automatic test_random();
        step_t s;
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(3, 0) != 0, 4'($urandom), $urandom_range(7, 0) == 0,
                 (k >= 380) || ($urandom_range(1, 0) == 1), s);
            checks++;
            if (s.obs_rdy !== s.exp_rdy || s.obs_vld !== s.exp_vld) begin
                errors++; $display("FAIL rand_hs rdy,vld obs=%b,%b exp=%b,%b", s.obs_rdy, s.obs_vld, s.exp_rdy, s.exp_vld);
            end
            if (s.rel) begin
                checks++;
                if (s.got_f !== s.exp_f || s.got_c !== s.exp_c) begin
                    errors++; $display("FAIL rand_release obs=%h/%0d exp=%h/%0d", s.got_f, s.got_c, s.exp_f, s.exp_c);
                end
            end
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 4'd0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_full_frame();
        test_short_frame();
        test_single_sample();
        test_hold_stall();
        test_reset_midfill();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
